// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg: shared constants and helpers for the channel mux/scanner.
//   - Default parameter values for 50 MHz board timing.
//   - Width helpers for the select index and the debounce/scan counters.
//   - Wrap-around increment/decrement rules for the channel index.
package chan_mux_pkg;

    localparam int unsigned DEF_WIDTH           = 4;
    localparam int unsigned DEF_CHANNELS        = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms at 50 MHz
    localparam int unsigned DEF_SCAN_DIV        = 50_000_000;  // 1 s at 50 MHz

    // Bits needed to index 0..channels-1 (at least 1).
    function automatic int unsigned sel_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Bits needed for a counter that runs 0..modulus-1 (at least 1).
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

    // Next channel going up, wrapping channels-1 -> 0.
    function automatic int unsigned wrap_inc(input int unsigned cur,
                                             input int unsigned channels);
        return (cur >= channels - 1) ? 0 : cur + 1;
    endfunction

    // Next channel going down, wrapping 0 -> channels-1.
    function automatic int unsigned wrap_dec(input int unsigned cur,
                                             input int unsigned channels);
        return (cur == 0) ? channels - 1 : cur - 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and press detector for
// one raw, bouncy, active-high button.
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   btn     in   raw button level
//   rise_c  out  combinational one-cycle pulse in the cycle the debounced
//                level is about to go 0 -> 1 (release produces nothing)
// The debounced level flips once the synchronised input has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module btn_debounce
    import chan_mux_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise_c
);

    localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             differ;
    logic             flip;

    // Two-stage synchroniser for the asynchronous button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    assign differ = (sync_q[1] != level_q);
    // cnt_q holds the number of disagreeing cycles already seen, so the
    // current disagreeing cycle is the last one needed when cnt_q == N-1.
    assign flip   = differ && (cnt_q == CNT_LAST);

    // Stability counter and level update.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (differ) begin
            if (flip) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Press only: level is low and about to flip high.
    assign rise_c = flip & ~level_q;

endmodule

// File: rtl/chan_mux_scanner.sv
// chan_mux_scanner: N-channel, WIDTH-bit selector with manual stepping from a
// debounced button or automatic scanning at a fixed rate.
// Optional feature macro: CHAN_MUX_DIR_EN (adds step_dir; 1 = step downwards).
//   CLOCK_50     in   system clock
//   reset        in   asynchronous active-high reset
//   ch_data      in   CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   step         in   raw step button (bouncy, asynchronous)
//   scan_en      in   raw mode switch: 1 = scan, 0 = manual
//   step_dir     in   raw direction switch (only with CHAN_MUX_DIR_EN)
//   sel          out  current channel index (registered)
//   data_out     out  registered ch_data[sel], one cycle behind sel/ch_data
//   sel_changed  out  one-cycle pulse in the cycle sel shows a new value
module chan_mux_scanner
    import chan_mux_pkg::*;
#(
    parameter  int unsigned WIDTH           = DEF_WIDTH,
    parameter  int unsigned CHANNELS        = DEF_CHANNELS,
    parameter  int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter  int unsigned SCAN_DIV        = DEF_SCAN_DIV,
    localparam int unsigned SEL_W           = sel_width(CHANNELS)
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    input  logic                      step,
    input  logic                      scan_en,
`ifdef CHAN_MUX_DIR_EN
    input  logic                      step_dir,
`endif
    output logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          data_out,
    output logic                      sel_changed
);

    localparam int unsigned      SCAN_W    = cnt_width(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic              step_pulse_c;
    logic [1:0]        scan_sync_q;
    logic              scan_on;
    logic              dir_down;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [SCAN_W-1:0] scan_cnt_d;
    logic              advance;
    logic [SEL_W-1:0]  sel_d;
    logic [WIDTH-1:0]  chan [CHANNELS];

    // Debounced press detector for the step button.
    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk    (CLOCK_50),
        .rst    (reset),
        .btn    (step),
        .rise_c (step_pulse_c)
    );

    // Mode switch synchroniser.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            scan_sync_q <= 2'b00;
        end else begin
            scan_sync_q <= {scan_sync_q[0], scan_en};
        end
    end

    assign scan_on = scan_sync_q[1];

`ifdef CHAN_MUX_DIR_EN
    logic [1:0] dir_sync_q;

    // Direction switch synchroniser.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            dir_sync_q <= 2'b00;
        end else begin
            dir_sync_q <= {dir_sync_q[0], step_dir};
        end
    end

    assign dir_down = dir_sync_q[1];
`else
    assign dir_down = 1'b0;
`endif

    // Advance source: scan terminal count in scan mode, debounced press in
    // manual mode. The scan counter sits at zero outside scan mode so every
    // scan period starts from a full SCAN_DIV.
    always_comb begin
        scan_cnt_d = '0;
        advance    = 1'b0;
        if (scan_on) begin
            if (scan_cnt_q == SCAN_LAST) begin
                advance = 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end else begin
            advance = step_pulse_c;
        end
    end

    // Next channel index with wrap in the selected direction.
    always_comb begin
        sel_d = sel;
        if (advance) begin
            if (dir_down) begin
                sel_d = SEL_W'(wrap_dec(32'(sel), CHANNELS));
            end else begin
                sel_d = SEL_W'(wrap_inc(32'(sel), CHANNELS));
            end
        end
    end

    // Unpack the flat channel bus so sel indexes whole channels.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign chan[i] = ch_data[i*WIDTH +: WIDTH];
    end

    // Select, change flag, scan counter and output registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sel         <= '0;
            sel_changed <= 1'b0;
            scan_cnt_q  <= '0;
            data_out    <= '0;
        end else begin
            sel         <= sel_d;
            sel_changed <= advance;
            scan_cnt_q  <= scan_cnt_d;
            data_out    <= chan[sel];
        end
    end

endmodule
